la_fifo_unpack: RTL and testbench



---
 rtl/la_fifo_unpack.sv | 97 +++++++++
 tb/tb_la_fifo_unpack.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_fifo_unpack.sv
// la_fifo_unpack: read-side drain stage for a synchronous FIFO.
// Pops DW-bit words from the FIFO's read port and serialises each word into
// RATIO beats of OW = DW/RATIO bits on a valid/ready stream.
// The output is driven from registers. The next word is popped in the same
// cycle that the last beat is accepted, so there is no bubble between words.
// Optional build macro: LA_FIFO_UNPACK_MSBFIRST_EN. When it is defined, the
// beat order is reversed so that beat 0 carries the MSBs of the word.
module la_fifo_unpack #(
    parameter int DW    = 32,
    parameter int RATIO = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    output logic                fifo_rd_en,
    input  logic [DW-1:0]       fifo_dout,
    input  logic                fifo_empty,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW/RATIO-1:0] out_data,
    output logic                out_last
);

    localparam int OW = DW / RATIO;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic [DW-1:0] hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;

    logic last_beat;
    logic accept;
    logic done;
    logic pop;

    assign last_beat = (cnt_q == LAST_CNT);
    assign accept    = valid_q & out_ready;
    assign done      = accept & last_beat;

    // A refill is allowed when the stage is empty, or when the final beat
    // leaves in this cycle. Popping is suppressed while reset or clear is
    // active so that the FIFO never loses a word that would be discarded.
    assign pop        = ~fifo_empty & (~valid_q | done) & ~reset & ~clear;
    assign fifo_rd_en = pop;

    assign out_valid = valid_q;
    assign out_last  = valid_q & last_beat;

    // Next-state selection: a pop takes precedence over the end of a word
    always_comb begin
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (pop) begin
            hold_d  = fifo_dout;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (done) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // State registers: clear drops the word in flight but keeps the hold data
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (clear) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Beat selection from the held word, indexed by the beat counter
    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CW'(i)) begin
`ifdef LA_FIFO_UNPACK_MSBFIRST_EN
                out_data = hold_q[(RATIO-1-i)*OW +: OW];
`else
                out_data = hold_q[i*OW +: OW];
`endif
            end
        end
    end

endmodule

// File: tb/tb_la_fifo_unpack.sv
// Testbench for la_fifo_unpack. A queue-based FIFO model feeds the DUT.
// The expected beats of every pushed word go into a scoreboard, and a monitor
// compares the DUT outputs against that scoreboard every cycle.
// A second instance with DW=8 and RATIO=1 covers the single-beat case.
module tb_la_fifo_unpack;

    localparam int DW    = 32;
    localparam int RATIO = 4;
    localparam int OW    = DW / RATIO;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clear, fifo_rd_en, fifo_empty;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] fifo_dout;
    logic [OW-1:0] out_data;

    la_fifo_unpack #(.DW(DW), .RATIO(RATIO)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    logic       r1_reset, r1_clear, r1_ready, r1_rd_en, r1_empty, r1_valid, r1_last;
    logic [7:0] r1_dout, r1_data;

    la_fifo_unpack #(.DW(8), .RATIO(1)) u_r1 (
        .clk        (clk),
        .reset      (r1_reset),
        .clear      (r1_clear),
        .fifo_rd_en (r1_rd_en),
        .fifo_dout  (r1_dout),
        .fifo_empty (r1_empty),
        .out_valid  (r1_valid),
        .out_ready  (r1_ready),
        .out_data   (r1_data),
        .out_last   (r1_last)
    );

    typedef struct {
        logic [OW-1:0] d;
        bit            last;
    } beat_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] fifo_q[$];
    beat_t         expq[$];
    int            inflight  = 0;
    bit            zero_hold = 1'b0;
    bit            armed     = 1'b0;
    int            n_acc     = 0;

    logic [7:0] r1_q[$];
    logic [7:0] r1_exp[$];
    int         r1_cyc = 0, r1_n = 0, r1_first = 0, r1_lastc = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEADBEEF;
        r1_empty   = (r1_q.size() == 0);
        r1_dout    = (r1_q.size() != 0) ? r1_q[0] : 8'hEE;
    endfunction

    // Push a word into the FIFO model and append its beats to the scoreboard
    function automatic void push_word(input logic [DW-1:0] w);
        beat_t b;
        int    idx;
        fifo_q.push_back(w);
        for (int k = 0; k < RATIO; k++) begin
`ifdef LA_FIFO_UNPACK_MSBFIRST_EN
            idx = RATIO - 1 - k;
`else
            idx = k;
`endif
            b.d    = w[idx*OW +: OW];
            b.last = (k == RATIO - 1);
            expq.push_back(b);
        end
        drive_fifo();
    endfunction

    // Monitor and reference model for the main instance
    bit    e_valid, e_acc, e_pop, do_pop;
    beat_t dropped;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            do_pop  = 1'b0;
            e_valid = (inflight > 0);
            e_acc   = e_valid && out_ready;
            e_pop   = (fifo_q.size() > 0) && (inflight == 0 || (e_acc && inflight == 1))
                      && !reset && !clear;
            if (armed) begin
                check("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
                check("fifo_rd_en", {63'd0, fifo_rd_en}, {63'd0, e_pop});
                if (e_valid) begin
                    check("out_data", {56'd0, out_data}, {56'd0, expq[0].d});
                    check("out_last", {63'd0, out_last}, {63'd0, expq[0].last});
                end else begin
                    check("out_last_idle", {63'd0, out_last}, 64'd0);
                    if (zero_hold)
                        check("out_data_after_reset", {56'd0, out_data}, 64'd0);
                end
            end
            if (reset || (armed && clear)) begin
                for (int k = 0; k < inflight; k++) dropped = expq.pop_front();
                inflight = 0;
                if (reset) begin
                    zero_hold = 1'b1;
                    armed     = 1'b1;
                end
            end else if (armed) begin
                if (e_acc) begin
                    dropped = expq.pop_front();
                    inflight--;
                    n_acc++;
                end
                if (e_pop) begin
                    inflight  = RATIO;
                    zero_hold = 1'b0;
                    do_pop    = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (do_pop) void'(fifo_q.pop_front());
            drive_fifo();
        end
    end

    // Monitor for the RATIO=1 instance
    bit r1_do_pop;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            r1_cyc++;
            r1_do_pop = 1'b0;
            if (!r1_reset) begin
                if (r1_valid && r1_ready) begin
                    if (r1_exp.size() == 0) begin
                        check("r1_unexpected_beat", {56'd0, r1_data}, 64'd0);
                    end else begin
                        check("r1_data", {56'd0, r1_data}, {56'd0, r1_exp[0]});
                        check("r1_last", {63'd0, r1_last}, 64'd1);
                        void'(r1_exp.pop_front());
                        if (r1_n == 0) r1_first = r1_cyc;
                        r1_lastc = r1_cyc;
                        r1_n++;
                    end
                end
                r1_do_pop = r1_rd_en;
            end
            @(posedge clk);
            #1;
            if (r1_do_pop && r1_q.size() > 0) void'(r1_q.pop_front());
            drive_fifo();
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((fifo_q.size() != 0 || inflight != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: drain timeout, fifo=%0d inflight=%0d, required 0/0", name, fifo_q.size(), inflight);
        end
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int n = 0;
        while (n_acc < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: accepted %0d beats, required %0d", name, n_acc, target);
        end
    endtask

    bit bp_pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        r1_reset  = 1'b1;
        r1_clear  = 1'b0;
        r1_ready  = 1'b1;
        drive_fifo();
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        r1_reset = 1'b0;

        // Single word, downstream always ready
        out_ready = 1'b1;
        push_word(32'hDDCCBBAA);
        wait_idle(50, "single_word");
        repeat (2) @(negedge clk);

        // Two words back to back
        push_word(32'h44332211);
        push_word(32'h88776655);
        wait_idle(50, "back_to_back");
        repeat (2) @(negedge clk);

        // Back-pressure with a second word waiting in the FIFO
        push_word(32'hDDCCBBAA);
        push_word(32'h01234567);
        foreach (bp_pat[i]) begin
            @(negedge clk);
            out_ready = bp_pat[i];
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_idle(50, "back_pressure");
        repeat (2) @(negedge clk);

        // Clear in the middle of a word
        push_word(32'hDDCCBBAA);
        push_word(32'h11223344);
        wait_acc(n_acc + 2, 20, "clear_setup");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_idle(50, "mid_word_clear");
        repeat (2) @(negedge clk);

        // Reset in the middle of a word with the FIFO non-empty
        push_word(32'hDDCCBBAA);
        push_word(32'h55667788);
        wait_acc(n_acc + 1, 20, "reset_setup");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_idle(50, "mid_word_reset");

        // Single-beat instance streaming three words
        r1_q.push_back(8'h01);
        r1_q.push_back(8'h02);
        r1_q.push_back(8'h03);
        r1_exp.push_back(8'h01);
        r1_exp.push_back(8'h02);
        r1_exp.push_back(8'h03);
        drive_fifo();
        repeat (8) @(negedge clk);
        check("r1_beat_count", 64'(r1_n), 64'd3);
        check("r1_consecutive", 64'(r1_lastc - r1_first), 64'd2);

        // Randomized traffic with back-pressure, clears and resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8)
                push_word($urandom);
        end
        @(negedge clk);
        clear     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        wait_idle(200, "random_drain");
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
